// File: rtl/riscvbc_mem_arbiter_pkg.sv
// Shared definitions for the two-requester memory arbiter.
// Latency: n/a (types, constants and size helpers only).
// Backpressure: n/a.
package riscvbc_mem_arbiter_pkg;

  // Width of the requester ID carried through the ID FIFO
  localparam int RISCVBC_ARB_ID_SZ = 1;

  // Requester identity; also used as the round-robin priority value
  typedef enum logic {
    ARB_REQ0 = 1'b0,
    ARB_REQ1 = 1'b1
  } arb_id_e;

  // Byte-length field width of the vc memory messages
  function automatic int mem_len_sz(input int data_sz);
    return $clog2(data_sz / 8);
  endfunction

  // Request message layout: {type, addr, len, data}
  function automatic int mem_req_msg_sz(input int addr_sz, input int data_sz);
    return 1 + addr_sz + mem_len_sz(data_sz) + data_sz;
  endfunction

  // Response message layout: {type, len, data}
  function automatic int mem_resp_msg_sz(input int data_sz);
    return 1 + mem_len_sz(data_sz) + data_sz;
  endfunction

endpackage

// File: rtl/riscvbc_ArbIdFifo.sv
// In-order FIFO of requester IDs for outstanding memory requests.
// Latency: a push becomes visible at the head on the next cycle.
// Backpressure: push ignored when full, pop ignored when empty; full/empty from registered occupancy.
module riscvbc_ArbIdFifo
  import riscvbc_mem_arbiter_pkg::*;
#(
  parameter int p_depth = 4
)
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [RISCVBC_ARB_ID_SZ-1:0] push_id,
  input  logic                         pop,
  output logic                         full,
  output logic                         empty,
  output logic [RISCVBC_ARB_ID_SZ-1:0] head
);

  localparam int c_ptr_sz = $clog2(p_depth);
  localparam logic [c_ptr_sz:0] c_full_occ = (c_ptr_sz + 1)'(p_depth);

  logic [RISCVBC_ARB_ID_SZ-1:0] id_mem [p_depth];
  logic [c_ptr_sz-1:0]          rd_ptr;
  logic [c_ptr_sz-1:0]          wr_ptr;
  logic [c_ptr_sz:0]            occ;
  logic                         do_push;
  logic                         do_pop;

  assign full    = (occ == c_full_occ);
  assign empty   = (occ == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = id_mem[rd_ptr];

  // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < p_depth; i++) id_mem[i] <= '0;
    end else begin
      if (do_push) begin
        id_mem[wr_ptr] <= push_id;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      occ <= occ + 1'b1;
      else if (!do_push && do_pop) occ <= occ - 1'b1;
    end
  end

endmodule

// File: rtl/riscvbc_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between I-cache (0) and D-cache (1) refill paths.
// Latency: 0 cycles on both request and response paths (pure muxing).
// Backpressure: requests stall when the ID FIFO is full or memory is not ready; responses stall on the owner's rdy.
module riscvbc_mem_arbiter
  import riscvbc_mem_arbiter_pkg::*;
#(
  parameter int p_addr_sz = 32,
  parameter int p_data_sz = 32,
  parameter int p_depth   = 4
)
(
  input  logic                                            clk,
  input  logic                                            reset,

  input  logic                                            req0_val,
  output logic                                            req0_rdy,
  input  logic [mem_req_msg_sz(p_addr_sz, p_data_sz)-1:0] req0_msg,
  output logic                                            resp0_val,
  input  logic                                            resp0_rdy,
  output logic [mem_resp_msg_sz(p_data_sz)-1:0]           resp0_msg,

  input  logic                                            req1_val,
  output logic                                            req1_rdy,
  input  logic [mem_req_msg_sz(p_addr_sz, p_data_sz)-1:0] req1_msg,
  output logic                                            resp1_val,
  input  logic                                            resp1_rdy,
  output logic [mem_resp_msg_sz(p_data_sz)-1:0]           resp1_msg,

  output logic                                            memreq_val,
  input  logic                                            memreq_rdy,
  output logic [mem_req_msg_sz(p_addr_sz, p_data_sz)-1:0] memreq_msg,
  input  logic                                            memresp_val,
  output logic                                            memresp_rdy,
  input  logic [mem_resp_msg_sz(p_data_sz)-1:0]           memresp_msg,

  output logic [31:0]                                     grant0_cnt,
  output logic [31:0]                                     grant1_cnt,
  output logic                                            proto_err
);

  arb_id_e                      prio;
  arb_id_e                      winner;
  arb_id_e                      head_sel;
  logic [RISCVBC_ARB_ID_SZ-1:0] head_id;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic                         fire;
  logic                         resp_fire;

  // Winner: the lone candidate, or the priority holder when both request
  always_comb begin
    winner = ARB_REQ0;
    if (req0_val && req1_val) winner = prio;
    else if (req1_val)        winner = ARB_REQ1;
  end

  // Request side; reset is folded in so nothing is offered while held in reset
  assign memreq_val = reset & (req0_val | req1_val) & ~fifo_full;
  assign memreq_msg = (winner == ARB_REQ1) ? req1_msg : req0_msg;
  assign req0_rdy   = reset & (winner == ARB_REQ0) & memreq_rdy & ~fifo_full;
  assign req1_rdy   = reset & (winner == ARB_REQ1) & memreq_rdy & ~fifo_full;
  assign fire       = memreq_val & memreq_rdy;

  // Response side: route to the oldest outstanding requester; empty FIFO blocks strays
  assign head_sel    = arb_id_e'(head_id);
  assign resp0_val   = memresp_val & ~fifo_empty & (head_sel == ARB_REQ0);
  assign resp1_val   = memresp_val & ~fifo_empty & (head_sel == ARB_REQ1);
  assign resp0_msg   = memresp_msg;
  assign resp1_msg   = memresp_msg;
  assign memresp_rdy = ~fifo_empty & ((head_sel == ARB_REQ1) ? resp1_rdy : resp0_rdy);
  assign resp_fire   = memresp_val & memresp_rdy;

  riscvbc_ArbIdFifo #(
    .p_depth (p_depth)
  ) u_id_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (fire),
    .push_id (winner),
    .pop     (resp_fire),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (head_id)
  );

  // Round-robin priority, grant counters and sticky stray-response flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio       <= ARB_REQ0;
      grant0_cnt <= '0;
      grant1_cnt <= '0;
      proto_err  <= 1'b0;
    end else begin
      if (fire) begin
        prio <= (winner == ARB_REQ0) ? ARB_REQ1 : ARB_REQ0;
        if (winner == ARB_REQ0) grant0_cnt <= grant0_cnt + 32'd1;
        else                    grant1_cnt <= grant1_cnt + 32'd1;
      end
      if (memresp_val && fifo_empty) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_riscvbc_mem_arbiter.sv
// Self-checking bench for riscvbc_mem_arbiter: directed scenarios plus a random phase.
// Reference model: queue of outstanding owners, priority bit, counters, and a memory model.
// Inputs change 1ns after posedge; outputs are sampled 2ns after posedge.
module tb_riscvbc_mem_arbiter;
  import riscvbc_mem_arbiter_pkg::*;

  localparam int DEPTH   = 4;
  localparam int REQ_SZ  = mem_req_msg_sz(32, 32);
  localparam int RESP_SZ = mem_resp_msg_sz(32);

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic req0_val, req0_rdy, resp0_val, resp0_rdy;
  logic req1_val, req1_rdy, resp1_val, resp1_rdy;
  logic [REQ_SZ-1:0]  req0_msg, req1_msg, memreq_msg;
  logic [RESP_SZ-1:0] resp0_msg, resp1_msg, memresp_msg;
  logic memreq_val, memreq_rdy, memresp_val, memresp_rdy;
  logic [31:0] grant0_cnt, grant1_cnt;
  logic proto_err;

  always #5 clk = ~clk;

  riscvbc_mem_arbiter #(.p_addr_sz(32), .p_data_sz(32), .p_depth(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_msg(req0_msg),
    .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_msg(resp0_msg),
    .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_msg(req1_msg),
    .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_msg(resp1_msg),
    .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_msg(memreq_msg),
    .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_msg(memresp_msg),
    .grant0_cnt(grant0_cnt), .grant1_cnt(grant1_cnt), .proto_err(proto_err)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // reference model state
  bit               m_q[$];
  bit               m_prio;
  logic [31:0]      m_cnt0, m_cnt1;
  bit               m_err;
  logic [RESP_SZ-1:0] mem_q[$];
  logic [RESP_SZ-1:0] exp0[$], exp1[$];
  logic [31:0]      plan_q[$];
  logic [31:0]      cap0[$], cap1[$];
  bit               mem_hold, stray;
  int               mem_maxdly, mem_wait;
  bit               obs_fire, obs_win;
  bit               win_log[$];
  int               nf;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [REQ_SZ-1:0] mk_req(input logic typ, input logic [31:0] a, input logic [31:0] d);
    return {typ, a, 2'b00, d};
  endfunction

  // One clock cycle: drive memory, check every output against the model, advance the model
  task automatic tick();
    bit full, empty, win, e_mv, e_r0, e_r1, e_v0, e_v1, e_mr, fire, pop, head;
    logic [RESP_SZ-1:0] rsp;
    logic [31:0] d;
    if (stray) begin
      memresp_val = 1'b1;
      memresp_msg = RESP_SZ'({$urandom, $urandom});
    end else if (!mem_hold && mem_q.size() > 0 && mem_wait == 0) begin
      memresp_val = 1'b1;
      memresp_msg = mem_q[0];
    end else begin
      memresp_val = 1'b0;
      memresp_msg = '0;
    end
    #1;
    full  = (m_q.size() == DEPTH);
    empty = (m_q.size() == 0);
    win   = (req0_val && req1_val) ? m_prio : req1_val;
    e_mv  = (req0_val || req1_val) && !full;
    e_r0  = !win && memreq_rdy && !full;
    e_r1  = win && memreq_rdy && !full;
    head  = empty ? 1'b0 : m_q[0];
    e_v0  = memresp_val && !empty && !head;
    e_v1  = memresp_val && !empty && head;
    e_mr  = !empty && (head ? resp1_rdy : resp0_rdy);
    chk("memreq_val", 128'(memreq_val), 128'(e_mv));
    chk("req0_rdy", 128'(req0_rdy), 128'(e_r0));
    chk("req1_rdy", 128'(req1_rdy), 128'(e_r1));
    chk("resp0_val", 128'(resp0_val), 128'(e_v0));
    chk("resp1_val", 128'(resp1_val), 128'(e_v1));
    chk("memresp_rdy", 128'(memresp_rdy), 128'(e_mr));
    chk("grant0_cnt", 128'(grant0_cnt), 128'(m_cnt0));
    chk("grant1_cnt", 128'(grant1_cnt), 128'(m_cnt1));
    chk("proto_err", 128'(proto_err), 128'(m_err));
    if (e_mv) chk("memreq_msg", 128'(memreq_msg), 128'(win ? req1_msg : req0_msg));
    fire = e_mv && memreq_rdy;
    pop  = memresp_val && e_mr;
    obs_fire = memreq_val & memreq_rdy;
    obs_win  = req1_rdy;
    if (resp0_val && resp0_rdy) cap0.push_back(resp0_msg[31:0]);
    if (resp1_val && resp1_rdy) cap1.push_back(resp1_msg[31:0]);
    if (pop && !head && exp0.size() > 0) chk("resp0_order", 128'(resp0_msg), 128'(exp0.pop_front()));
    if (pop && head && exp1.size() > 0)  chk("resp1_order", 128'(resp1_msg), 128'(exp1.pop_front()));
    @(posedge clk);
    if (memresp_val && empty) m_err = 1'b1;
    if (pop) begin
      void'(m_q.pop_front());
      void'(mem_q.pop_front());
      mem_wait = int'($urandom_range(mem_maxdly, 0));
    end else if (mem_wait > 0) begin
      mem_wait--;
    end
    if (fire) begin
      m_q.push_back(win);
      m_prio = !win;
      if (win) m_cnt1++; else m_cnt0++;
      d = (plan_q.size() > 0) ? plan_q.pop_front() : $urandom;
      rsp = {1'b0, 2'b10, d};
      if (mem_q.size() == 0) mem_wait = int'($urandom_range(mem_maxdly, 0));
      mem_q.push_back(rsp);
      if (win) exp1.push_back(rsp); else exp0.push_back(rsp);
    end
    #1;
  endtask

  // Assert reset mid-cycle, check that every output is cleared, clear the model
  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_memreq_val", 128'(memreq_val), 128'(0));
    chk("rst_req0_rdy", 128'(req0_rdy), 128'(0));
    chk("rst_req1_rdy", 128'(req1_rdy), 128'(0));
    chk("rst_resp0_val", 128'(resp0_val), 128'(0));
    chk("rst_resp1_val", 128'(resp1_val), 128'(0));
    chk("rst_memresp_rdy", 128'(memresp_rdy), 128'(0));
    chk("rst_grant0_cnt", 128'(grant0_cnt), 128'(0));
    chk("rst_grant1_cnt", 128'(grant1_cnt), 128'(0));
    chk("rst_proto_err", 128'(proto_err), 128'(0));
    m_q.delete(); mem_q.delete(); exp0.delete(); exp1.delete();
    m_prio = 1'b0; m_cnt0 = '0; m_cnt1 = '0; m_err = 1'b0; mem_wait = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Stop requesting and let memory return everything outstanding, bounded
  task automatic drain();
    req0_val = 1'b0; req1_val = 1'b0; stray = 1'b0; mem_hold = 1'b0;
    resp0_rdy = 1'b1; resp1_rdy = 1'b1;
    for (int i = 0; i < 60 && m_q.size() > 0; i++) tick();
    n_cmp++;
    assert (m_q.size() == 0) else begin
      n_fail++;
      $error("FAIL drain_timeout: outstanding %0d required 0", m_q.size());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req0_val = 0; req1_val = 0; req0_msg = '0; req1_msg = '0;
    resp0_rdy = 1; resp1_rdy = 1; memreq_rdy = 1;
    memresp_val = 0; memresp_msg = '0;
    mem_hold = 0; stray = 0; mem_maxdly = 0; mem_wait = 0;
    #2;
    do_reset();

    // single requester: read 0x1000 returns 0xDEADBEEF to requester 0
    plan_q.push_back(32'hDEADBEEF);
    req0_val = 1; req0_msg = mk_req(1'b0, 32'h1000, 32'h0);
    tick();
    drain();
    chk("single_grant0", 128'(grant0_cnt), 128'(1));
    chk("single_grant1", 128'(grant1_cnt), 128'(0));
    chk("single_cap0_n", 128'(cap0.size()), 128'(1));
    chk("single_cap0_data", 128'(cap0[0]), 128'(32'hDEADBEEF));
    chk("single_cap1_n", 128'(cap1.size()), 128'(0));

    // contention from reset: 0,1,0,1,0,1
    do_reset();
    req0_val = 1; req1_val = 1;
    req0_msg = mk_req(1'b0, 32'h2000, 32'h0);
    req1_msg = mk_req(1'b1, 32'h3000, 32'h55);
    win_log.delete();
    for (int i = 0; i < 6; i++) begin
      tick();
      if (obs_fire) win_log.push_back(obs_win);
    end
    chk("cont_fires", 128'(win_log.size()), 128'(6));
    for (int i = 0; i < 6; i++) chk($sformatf("cont_order%0d", i), 128'(win_log[i]), 128'(i % 2));
    chk("cont_grant0", 128'(grant0_cnt), 128'(3));
    chk("cont_grant1", 128'(grant1_cnt), 128'(3));
    drain();

    // routing under random delay: IDs 1,0,1 carry A,B,C
    cap0.delete(); cap1.delete();
    mem_maxdly = 4;
    plan_q.push_back(32'hA); plan_q.push_back(32'hB); plan_q.push_back(32'hC);
    req1_val = 1; req0_val = 0; tick();
    req1_val = 0; req0_val = 1; tick();
    req1_val = 1; req0_val = 0; tick();
    drain();
    chk("route_cap1_n", 128'(cap1.size()), 128'(2));
    chk("route_cap0_n", 128'(cap0.size()), 128'(1));
    chk("route_r1_first", 128'(cap1[0]), 128'(32'hA));
    chk("route_r0", 128'(cap0[0]), 128'(32'hB));
    chk("route_r1_second", 128'(cap1[1]), 128'(32'hC));

    // full FIFO: four fires then stall; one release gives one fire a cycle later
    mem_maxdly = 0; mem_hold = 1;
    req0_val = 1; req1_val = 1;
    nf = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      nf += int'(obs_fire);
    end
    chk("full_fires", 128'(nf), 128'(4));
    #1;
    chk("full_memreq_val", 128'(memreq_val), 128'(0));
    chk("full_req0_rdy", 128'(req0_rdy), 128'(0));
    chk("full_req1_rdy", 128'(req1_rdy), 128'(0));
    mem_hold = 0; mem_wait = 0;
    tick();
    chk("full_release_cycle_fire", 128'(obs_fire), 128'(0));
    tick();
    chk("full_next_cycle_fire", 128'(obs_fire), 128'(1));
    drain();

    // backpressure on requester 1 holds the head
    req1_val = 1; tick();
    req1_val = 0; resp1_rdy = 0;
    tick(); tick();
    #1;
    chk("bp_memresp_rdy_low", 128'(memresp_rdy), 128'(0));
    chk("bp_resp1_val", 128'(resp1_val), 128'(1));
    resp1_rdy = 1;
    #1;
    chk("bp_memresp_rdy_high", 128'(memresp_rdy), 128'(1));
    tick();
    #1;
    chk("bp_popped", 128'(resp1_val), 128'(0));
    drain();

    // stray response, then reset with two requests outstanding
    stray = 1; tick();
    stray = 0; tick();
    chk("stray_proto_err", 128'(proto_err), 128'(1));
    tick();
    chk("stray_sticky", 128'(proto_err), 128'(1));
    mem_hold = 1;
    req0_val = 1; tick();
    req0_val = 0; req1_val = 1; tick();
    req0_val = 1; req1_val = 1;
    do_reset();
    tick();
    chk("post_reset_fire", 128'(obs_fire), 128'(1));
    chk("post_reset_winner", 128'(obs_win), 128'(0));
    drain();

    // random traffic against the model
    mem_maxdly = 3;
    for (int i = 0; i < 400; i++) begin
      req0_val   = 1'($urandom % 2);
      req1_val   = 1'($urandom % 2);
      req0_msg   = mk_req(1'($urandom % 2), $urandom, $urandom);
      req1_msg   = mk_req(1'($urandom % 2), $urandom, $urandom);
      memreq_rdy = ($urandom % 4) != 0;
      resp0_rdy  = ($urandom % 3) != 0;
      resp1_rdy  = ($urandom % 3) != 0;
      tick();
    end
    memreq_rdy = 1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
